challenge_poly_reader: RTL and testbench

- Reader counterpart of the challenge sampler: after the sampler has written c (256 coefficients, 4 per 96-bit word) into NTT data RAM, this block reads it back.
- Validates each coefficient as one of {0, 1, Q-1} and counts the Hamming weight.
- Streams c out in compact 2-bit-per-coefficient form over a valid/ready interface, 64 bits per beat, for signature packing and for debug readback.

---
 rtl/challenge_poly_reader.sv | 176 +++++++++++++++++
 tb/tb_challenge_poly_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/challenge_poly_reader.sv
// challenge_poly_reader
//   Reads the challenge polynomial c (256 coefficients, 4 per 96-bit word)
//   back from NTT data RAM. Each coefficient is checked against {0, 1, Q-1}.
//   The block can also count the Hamming weight of c. c is streamed out as
//   2-bit codes, 64 bits per valid/ready beat, giving 8 beats per polynomial.
//   Code map: 0 -> 00, 1 -> 01, Q-1 -> 10, anything else -> 11.
//
// Build option:
//   HAMMING_CHECK_EN  When defined, a saturating weight counter is built and
//                     weight_ok is (weight == TAU). When it is not defined,
//                     weight_ok is 1 from done onward.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         1-cycle pulse. Accepted only in IDLE.
//   done          1-cycle pulse after the last beat is accepted
//   weight_ok     weight check result. Valid from done, held until next start.
//   fmt_ok        all coefficients legal. Valid from done, held until next start.
//   re_poly_c     RAM read enable
//   addr_poly_c   RAM word address
//   dout_poly_c   RAM read data. It is valid one cycle after re_poly_c.
//   data_out      packed beat. Coefficient 32k+i sits at bits [2i+1:2i] of beat k.
//   out_valid     data_out valid
//   out_ready     downstream accept
module challenge_poly_reader #(
    parameter int N                    = 256,
    parameter int TAU                  = 60,
    parameter int Q                    = 8380417,
    parameter int COEFF_WIDTH          = 24,
    parameter int COEFF_PER_WORD       = 4,
    parameter int WORD_COEFF           = COEFF_WIDTH * COEFF_PER_WORD,
    parameter int TOTAL_COEFF          = 4096,
    parameter int NTT_ADDR_WIDTH       = $clog2(TOTAL_COEFF),
    parameter int VECTOR_C_BASE_OFFSET = 0,
    parameter int WORD_WIDTH           = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    output logic                      weight_ok,
    output logic                      fmt_ok,
    output logic                      re_poly_c,
    output logic [NTT_ADDR_WIDTH-1:0] addr_poly_c,
    input  logic [WORD_COEFF-1:0]     dout_poly_c,
    output logic [WORD_WIDTH-1:0]     data_out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int BEATS          = (2 * N) / WORD_WIDTH;                    // 8
    localparam int WORDS_PER_BEAT = WORD_WIDTH / (2 * COEFF_PER_WORD);       // 8
    localparam int CODE_BITS      = 2 * COEFF_PER_WORD;                      // 8

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(1);
    localparam logic [COEFF_WIDTH-1:0] COEFF_NEG = COEFF_WIDTH'(Q - 1);

    logic [1:0] state;
    logic [5:0] word_cnt;
    logic [2:0] beat_cnt;
    // Each beat uses 9 FETCH sub-cycles. Sub-cycles 0..7 issue reads.
    // Sub-cycles 1..8 capture the word read in the previous sub-cycle.
    logic [3:0] fcnt;
    logic [2:0] widx;
    logic       fmt_acc;

    logic [CODE_BITS-1:0] code;
    logic [2:0]           nz_cnt;
    logic                 bad;

    function automatic logic [1:0] enc(input logic [COEFF_WIDTH-1:0] v);
        if (v == '0)             return 2'b00;
        else if (v == COEFF_ONE) return 2'b01;
        else if (v == COEFF_NEG) return 2'b10;
        else                     return 2'b11;
    endfunction

    always_comb begin
        code   = '0;
        nz_cnt = '0;
        bad    = 1'b0;
        for (int unsigned m = 0; m < COEFF_PER_WORD; m++) begin
            code[2*m +: 2] = enc(dout_poly_c[COEFF_WIDTH*m +: COEFF_WIDTH]);
            if (code[2*m +: 2] != 2'b00) nz_cnt = nz_cnt + 3'd1;
            if (code[2*m +: 2] == 2'b11) bad = 1'b1;
        end
    end

    assign widx        = fcnt[2:0] - 3'd1;   // fcnt = 8 maps to lane 7
    assign re_poly_c   = (state == S_FETCH) && (fcnt < 4'(WORDS_PER_BEAT));
    assign addr_poly_c = re_poly_c ? NTT_ADDR_WIDTH'(VECTOR_C_BASE_OFFSET) + NTT_ADDR_WIDTH'(word_cnt) : '0;
    assign out_valid   = (state == S_EMIT);
    assign done        = (state == S_DONE);

`ifdef HAMMING_CHECK_EN
    logic [8:0] weight;
    logic [9:0] weight_sum;
    assign weight_sum = {1'b0, weight} + 10'(nz_cnt);
`else
    logic unused_nz;
    assign unused_nz = ^nz_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            fcnt      <= '0;
            fmt_acc   <= 1'b0;
            weight_ok <= 1'b0;
            fmt_ok    <= 1'b0;
            data_out  <= '0;
`ifdef HAMMING_CHECK_EN
            weight    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
`ifdef HAMMING_CHECK_EN
                        weight <= '0;
`endif
                        fmt_acc   <= 1'b1;
                        weight_ok <= 1'b0;
                        fmt_ok    <= 1'b0;
                        word_cnt  <= '0;
                        beat_cnt  <= '0;
                        fcnt      <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (re_poly_c) word_cnt <= word_cnt + 6'd1;
                    if (fcnt != 4'd0) begin
                        data_out[CODE_BITS*widx +: CODE_BITS] <= code;
                        if (bad) fmt_acc <= 1'b0;
`ifdef HAMMING_CHECK_EN
                        weight <= (weight_sum > 10'(N)) ? 9'(N) : weight_sum[8:0];
`endif
                    end
                    if (fcnt == 4'(WORDS_PER_BEAT)) begin
                        fcnt  <= '0;
                        state <= S_EMIT;
                    end else begin
                        fcnt <= fcnt + 4'd1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'(BEATS - 1)) begin
                            // Results are latched on entry to DONE, so they are valid during the done pulse.
`ifdef HAMMING_CHECK_EN
                            weight_ok <= (weight == 9'(TAU));
`else
                            weight_ok <= 1'b1;
`endif
                            fmt_ok    <= fmt_acc;
                            state     <= S_DONE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_challenge_poly_reader.sv
module tb_challenge_poly_reader;

    localparam int          Q_MOD = 8380417;
    localparam logic [23:0] NEG1  = 24'(Q_MOD - 1);
`ifdef HAMMING_CHECK_EN
    localparam logic        HC = 1'b1;
`else
    localparam logic        HC = 1'b0;
`endif

    logic        clk, rst, start, done, weight_ok, fmt_ok, re_poly_c, out_valid, out_ready;
    logic [11:0] addr_poly_c;
    logic [95:0] dout_poly_c;
    logic [63:0] data_out;

    int checks = 0;
    int errors = 0;

    challenge_poly_reader dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .weight_ok(weight_ok), .fmt_ok(fmt_ok),
        .re_poly_c(re_poly_c), .addr_poly_c(addr_poly_c), .dout_poly_c(dout_poly_c),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model RAM with one cycle of read latency. Words live at 0..63.
    logic [23:0] c [256];
    always @(posedge clk) begin
        if (re_poly_c) begin
            for (int m = 0; m < 4; m++)
                dout_poly_c[24*m +: 24] <= c[4*addr_poly_c[5:0] + m];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input int id);
        for (int i = 0; i < 256; i++) c[i] = 24'd0;
        case (id)
            0: for (int i = 0; i < 60; i++) c[i] = 24'd1;
            1: begin
                for (int i = 0; i < 59; i++) c[i] = 24'd1;
                c[5]   = NEG1;
                c[255] = 24'd1;
            end
            default: begin
                for (int i = 0; i < 61; i++) c[i] = 24'd1;
                c[17] = 24'd2;
            end
        endcase
    endtask

    typedef struct {
        int               id;
        logic [7:0][63:0] beats;
        logic             wok;
        logic             fok;
        int               stall_beat;
        int               stall_len;
        bit               emit_start;
        int               done_cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0, beats = 0, dones = 0, done_cyc = -1, first_valid = -1;
        int stall_left = 0;
        bit stall_started = 0, rdy;
        logic [63:0] held = '0;
        load(v.id);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            rdy = 1'b1;
            if (out_valid && beats == v.stall_beat && !stall_started) begin
                stall_started = 1;
                stall_left = v.stall_len;
                held = data_out;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                check({tag, " stall_data"}, data_out, held);
                check({tag, " stall_re"}, 64'(re_poly_c), 64'd0);
            end
            out_ready = rdy;
            if (v.emit_start && out_valid && beats == 1) start = 1'b1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && rdy) begin
                if (beats < 8) check($sformatf("%s beat%0d", tag, beats), data_out, v.beats[beats]);
                beats++;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
        end
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(v.done_cyc));
        check({tag, " first_valid"}, 64'(first_valid), 64'd10);
        check({tag, " beats"}, 64'(beats), 64'd8);
        check({tag, " dones"}, 64'(dones), 64'd1);
        check({tag, " weight_ok"}, 64'(weight_ok), 64'(v.wok));
        check({tag, " fmt_ok"}, 64'(fmt_ok), 64'(v.fok));
        out_ready = 1'b1;
    endtask

    int extra;

    initial begin
        vecs[0] = '{0, {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                        64'h0055_5555_5555_5555, 64'h5555_5555_5555_5555},
                    1'b1, 1'b1, -1, 0, 0, 81};
        vecs[1] = '{1, {64'h4000_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                        64'h0015_5555_5555_5555, 64'h5555_5555_5555_5955},
                    1'b1, 1'b1, -1, 0, 0, 81};
        vecs[2] = '{2, {64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                        64'h0155_5555_5555_5555, 64'h5555_555D_5555_5555},
                    ~HC, 1'b0, -1, 0, 0, 81};
        vecs[3] = vecs[0];
        vecs[3].stall_beat = 3; vecs[3].stall_len = 5; vecs[3].done_cyc = 86;
        vecs[4] = vecs[0];
        vecs[4].emit_start = 1;

        rst = 1'b0; start = 1'b0; out_ready = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check("reset outputs", {data_out}, 64'd0);
        check("reset ctrl", 64'({done, re_poly_c, out_valid, weight_ok, fmt_ok, addr_poly_c}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // The start pulse during EMIT in vec4 must not begin a second pass.
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid || re_poly_c || done) extra++;
        end
        check("emit_start no rerun", 64'(extra), 64'd0);

        // Reset asserted during the beat 2 fetch (cycles 21..30).
        load(0);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst data", data_out, 64'd0);
        check("midrst ctrl", 64'({done, re_poly_c, out_valid, weight_ok, fmt_ok, addr_poly_c}), 64'd0);
        extra = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (done || out_valid) extra++;
        end
        check("midrst no activity", 64'(extra), 64'd0);
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
